// File: rtl/regbank_wb_arbiter.sv
// Arbitrates register-bank writeback (A = pipeline, B = multi-cycle unit) with a 1-cycle registered write and a pending scoreboard.
// Define REGBANK_WB_STARVE_GUARD_EN to force a B grant after STARVE_LIMIT consecutive refusals.
module regbank_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [ADDR_W-1:0] q0_addr,
    input  logic [ADDR_W-1:0] q1_addr,
    output logic              q0_busy,
    output logic              q1_busy,
    output logic [ADDR_W-1:0] wAddr,
    output logic [DATA_W-1:0] wData,
    output logic              wEn
);
    localparam int NREG = 2**ADDR_W;

    logic [NREG-1:0]   r_pending;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wen;
    logic              r_from_b;

    logic              w_force_b;
    logic              w_a_grant;
    logic              w_b_grant;
    logic              w_iss_grant;
    logic [NREG-1:0]   w_set_mask;
    logic [NREG-1:0]   w_clr_mask;

`ifdef REGBANK_WB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] r_starve;

    // Counter only advances while B is actually waiting; it parks at the limit.
    assign w_force_b = (r_starve == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_starve <= '0;
        end else if (!b_valid || w_b_grant) begin
            r_starve <= '0;
        end else if (!w_force_b) begin
            r_starve <= r_starve + CNT_W'(1);
        end
    end
`else
    assign w_force_b = 1'b0;
`endif

    assign w_a_grant   = reset & a_valid & ~w_force_b;
    assign w_b_grant   = reset & b_valid & (w_force_b | ~a_valid);
    assign w_iss_grant = reset & iss_valid & iss_ready;

    assign a_ready   = w_a_grant;
    assign b_ready   = w_b_grant;
    assign iss_ready = reset & ((iss_addr == '0) | ~r_pending[iss_addr]);

    assign q0_busy = (q0_addr != '0) & r_pending[q0_addr];
    assign q1_busy = (q1_addr != '0) & r_pending[q1_addr];

    assign wAddr = r_waddr;
    assign wData = r_wdata;
    assign wEn   = r_wen;

    // Register 0 is hardwired: its writes are absorbed with the enable held low.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_wen    <= 1'b0;
            r_from_b <= 1'b0;
        end else if (w_a_grant) begin
            r_waddr  <= a_addr;
            r_wdata  <= a_data;
            r_wen    <= (a_addr != '0);
            r_from_b <= 1'b0;
        end else if (w_b_grant) begin
            r_waddr  <= b_addr;
            r_wdata  <= b_data;
            r_wen    <= (b_addr != '0);
            r_from_b <= 1'b1;
        end else begin
            r_wen    <= 1'b0;
            r_from_b <= 1'b0;
        end
    end

    // Pending bit drops on the same edge the bank captures the B result.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_iss_grant && (iss_addr != '0)) begin
            w_set_mask[iss_addr] = 1'b1;
        end
        if (r_wen && r_from_b) begin
            w_clr_mask[r_waddr] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Bench for regbank_wb_arbiter: directed steps then constrained-random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_regbank_wb_arbiter;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int LIM = 4;
`ifdef REGBANK_WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0, iss_valid = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0, iss_addr = '0, q0_addr = '0, q1_addr = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          a_ready, b_ready, iss_ready, q0_busy, q1_busy, wEn;
    logic [AW-1:0] wAddr;
    logic [DW-1:0] wData;

    regbank_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
        .CLK(CLK), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_addr(iss_addr),
        .q0_addr(q0_addr), .q1_addr(q1_addr), .q0_busy(q0_busy), .q1_busy(q1_busy),
        .wAddr(wAddr), .wData(wData), .wEn(wEn)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Model state: set of pending registers, the write expected on the bank port, B wait streak.
    bit            m_pend [32];
    bit            m_wen;
    bit            m_fromb;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            m_starve;
    bit            g_a, g_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_wen = 1'b0; m_fromb = 1'b0; m_waddr = '0; m_wdata = '0; m_starve = 0;
    endtask

    // Check one cycle at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        bit force_b, ea, eb, ei;
        @(negedge CLK);
        force_b = GUARD && (m_starve >= LIM);
        ea = a_valid && !force_b;
        eb = b_valid && (force_b || !a_valid);
        ei = (iss_addr == 0) || !m_pend[iss_addr];
        check("a_ready", 32'(a_ready), 32'(ea));
        check("b_ready", 32'(b_ready), 32'(eb));
        check("iss_ready", 32'(iss_ready), 32'(ei));
        check("q0_busy", 32'(q0_busy), 32'((q0_addr != 0) && m_pend[q0_addr]));
        check("q1_busy", 32'(q1_busy), 32'((q1_addr != 0) && m_pend[q1_addr]));
        check("wEn", 32'(wEn), 32'(m_wen));
        check("wAddr", 32'(wAddr), 32'(m_waddr));
        check("wData", wData, m_wdata);
        if (m_wen && m_fromb) m_pend[m_waddr] = 1'b0;
        if (iss_valid && ei && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        if (ea) begin
            m_wen = (a_addr != 0); m_waddr = a_addr; m_wdata = a_data; m_fromb = 1'b0;
        end else if (eb) begin
            m_wen = (b_addr != 0); m_waddr = b_addr; m_wdata = b_data; m_fromb = 1'b1;
        end else begin
            m_wen = 1'b0; m_fromb = 1'b0;
        end
        if (!b_valid || eb) m_starve = 0;
        else if (m_starve < LIM) m_starve++;
        g_a = ea; g_b = eb;
        @(posedge CLK); #1;
    endtask

    initial begin
        // Reset held low: every ready gated, bank port quiet.
        a_valid = 1'b1; b_valid = 1'b1; iss_valid = 1'b1; iss_addr = 5'd3;
        #12;
        check("rst_wEn", 32'(wEn), 32'd0);
        check("rst_wAddr", 32'(wAddr), 32'd0);
        check("rst_wData", wData, 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        check("rst_iss_ready", 32'(iss_ready), 32'd0);
        a_valid = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
        @(posedge CLK); #1;
        reset = 1'b1;
        model_reset();
        repeat (3) cycle();

        // Single A write.
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        cycle();
        a_valid = 1'b0;
        cycle();
        cycle();

        // A/B contention.
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h0000_0033;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h0000_0077;
        repeat (10) cycle();
        a_valid = 1'b0; b_valid = 1'b0;
        cycle();

        // Scoreboard set, re-issue stall, clear on B writeback.
        iss_valid = 1'b1; iss_addr = 5'd9; q0_addr = 5'd9;
        cycle();
        cycle();
        iss_valid = 1'b0;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'hCAFE_0009;
        cycle();
        b_valid = 1'b0;
        cycle();
        cycle();

        // Register 0.
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h0000_1234;
        cycle();
        a_valid = 1'b0;
        iss_valid = 1'b1; iss_addr = 5'd0; q0_addr = 5'd0;
        cycle();
        iss_valid = 1'b0;
        cycle();

        // Async reset between a B grant and its writeback.
        iss_valid = 1'b1; iss_addr = 5'd9; q0_addr = 5'd9;
        cycle();
        iss_valid = 1'b0;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h9999_0000;
        cycle();
        b_valid = 1'b0;
        #1 reset = 1'b0;
        b_valid = 1'b1;
        #1;
        check("arst_wEn", 32'(wEn), 32'd0);
        check("arst_b_ready", 32'(b_ready), 32'd0);
        check("arst_q0_busy", 32'(q0_busy), 32'd0);
        b_valid = 1'b0;
        model_reset();
        @(posedge CLK); #1;
        reset = 1'b1;
        cycle();
        cycle();

        // Random traffic; requesters hold until accepted.
        for (int n = 0; n < 400; n++) begin
            if (!a_valid || g_a) begin
                a_valid = ($urandom_range(0, 2) == 0);
                a_addr  = AW'($urandom_range(0, 7));
                a_data  = $urandom;
            end
            if (!b_valid || g_b) begin
                b_valid = ($urandom_range(0, 1) == 0);
                b_addr  = AW'($urandom_range(0, 7));
                b_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_addr  = AW'($urandom_range(0, 7));
            q0_addr   = AW'($urandom_range(0, 7));
            q1_addr   = AW'($urandom_range(0, 31));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regbank_wb_arbiter.md
Name: regbank_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register bank between two writeback sources.
  - Source A: main pipeline writeback (ALU results).
  - Source B: multi-cycle unit writeback (load / mul / div).
- Keeps a 32-bit pending scoreboard of registers awaiting a B result, so decode can stall reads on them.
- Sits between writeback sources and register bank. Drives the bank's wAddr/wData/wEn.

Parameters:
- DATA_W, 32, data width of write port.
- ADDR_W, 5, register address width (2**ADDR_W registers).
- STARVE_LIMIT, 4, consecutive cycles B may be refused before forced grant (used only with the optional feature).

Ports:
- CLK  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- a_valid  input  1  source A write request.
- a_ready  output  1  A accepted this cycle (combinational).
- a_addr  input  ADDR_W  A destination register.
- a_data  input  DATA_W  A write data.
- b_valid  input  1  source B write request.
- b_ready  output  1  B accepted this cycle (combinational).
- b_addr  input  ADDR_W  B destination register.
- b_data  input  DATA_W  B write data.
- iss_valid  input  1  multi-cycle op issuing; marks destination pending.
- iss_ready  output  1  issue accepted (combinational).
- iss_addr  input  ADDR_W  destination of issuing op.
- q0_addr, q1_addr  input  ADDR_W  decode read addresses to check.
- q0_busy, q1_busy  output  1  queried register pending (combinational from scoreboard).
- wAddr  output  ADDR_W  to register bank, registered.
- wData  output  DATA_W  to register bank, registered.
- wEn  output  1  to register bank, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - wEn=0, wAddr=0, wData=0.
  - Scoreboard cleared to 0; starvation counter = 0.
  - a_ready=0, b_ready=0, iss_ready=0 while reset low.
- Reset applied mid-operation: any granted-but-unwritten write is discarded; all pending bits are lost.
- Arbitration, per cycle:
  - Base rule (feature off or not starving): A has priority.
    - a_ready = a_valid.
    - b_ready = b_valid & ~a_valid.
  - At most one of a_ready/b_ready is high in any cycle.
  - Handshake completes when valid & ready. Requesters hold addr/data stable until ready.
- Write latency: granted request appears on wAddr/wData/wEn exactly one cycle after the grant edge, for exactly one cycle.
  - Example: grant in cycle t → wEn=1 during t+1 → bank writes at end of t+1.
  - wEn=0 in any cycle following a no-grant cycle.
- Register 0:
  - Granted writes with addr 0 complete the handshake but produce wEn=0 (wAddr/wData still updated).
  - Issue to addr 0 is accepted and sets no pending bit.
- Scoreboard:
  - Set: bit iss_addr sets on the edge where iss_valid & iss_ready.
  - iss_ready = ~pending[iss_addr] (addr 0 always ready). Re-issue to a pending register stalls, so set and clear of the same bit never coincide.
  - Clear: bit wAddr clears on the edge where wEn=1 and the registered write came from B, i.e. the same edge the bank is written. No window exists where the bit is clear but the data is stale.
  - A writes never touch the scoreboard.
  - Set of register X and clear of register Y≠X in the same edge: both take effect.
- Query outputs: qN_busy = pending[qN_addr]; q addr 0 → 0.

Optional Feature:
- Macro: REGBANK_WB_STARVE_GUARD_EN.
- Defined:
  - Counter increments each cycle b_valid & ~b_ready, saturating at STARVE_LIMIT.
  - Counter resets to 0 on a B grant or when b_valid=0.
  - When counter == STARVE_LIMIT: b_ready = b_valid, a_ready = 0 for that cycle (A stalls one cycle).
- Undefined: strict A priority. B may starve indefinitely. No counter logic synthesised.

Test Plan:
- Reset release, idle inputs → wEn=0, q0_busy=0, iss_ready=1, all bits clear for 3 cycles.
- Single A write: a_valid=1, a_addr=5, a_data=0xDEADBEEF in cycle t → a_ready=1 at t; wEn=1, wAddr=5, wData=0xDEADBEEF at t+1 only.
- Contention:
  - Setup: a_valid and b_valid both high; A addr 3, B addr 7.
  - Feature off: A granted every cycle; b_ready=0 for 10 cycles.
  - Feature on, STARVE_LIMIT=4: b_ready=1 in the 5th contention cycle, a_ready=0 that cycle.
- Scoreboard:
  - Issue addr 9 → q0_addr=9 gives q0_busy=1 next cycle.
  - Second issue to 9 → iss_ready=0.
  - B write to 9 granted at t → busy stays 1 through t+1, becomes 0 at t+2.
- Zero register: A write addr 0 data 0x1234 → a_ready=1, next-cycle wEn=0. Issue addr 0 → q0_addr=0 busy stays 0.
- Async reset mid-write: grant B addr 9, assert reset=0 before next edge → wEn=0 immediately, pending[9]=0 after release.
